bus_master_if: RTL

//  Bus-master front end feeding bus_arbiter: one instance per master (m0..m3).

---
 rtl/bus_master_if.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bus_master_if.sv
// Single-word bus-master front end: turns a client read/write into a request/grant/strobe
// handshake on the shared bus, finishing on slave ready or aborting after TIMEOUT cycles.
module bus_master_if #(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_as,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    input  logic              cpu_flush,
    output logic              cpu_busy,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    localparam int unsigned TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REQ    = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               req_q, req_d;
    logic               as_q, as_d;
    logic               rw_q, rw_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        req_d   = req_q;
        as_d    = as_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_as && !cpu_flush) begin
                    addr_d  = cpu_addr;
                    rw_d    = cpu_rw;
                    wdata_d = cpu_wr_data;
                    req_d   = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (cpu_flush) begin
                    req_d   = 1'b1;
                    state_d = IDLE;
                end else if (!bus_grnt_) begin
                    as_d    = 1'b0;
                    timer_d = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Flush is deliberately ignored here: the slave may already have acted.
                if (!bus_rdy_) begin
                    as_d    = 1'b1;
                    req_d   = 1'b1;
                    done_d  = 1'b1;
                    if (rw_q) rdata_d = bus_rd_data;
                    state_d = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    as_d    = 1'b1;
                    req_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                req_d   = 1'b1;
                as_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            req_q   <= 1'b1;
            as_q    <= 1'b1;
            rw_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            as_q    <= as_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cpu_busy    = (state_q != IDLE) | (cpu_as & ~cpu_flush);
    assign cpu_rd_data = rdata_q;
    assign cpu_done    = done_q;
    assign cpu_err     = err_q;
    assign bus_req_    = req_q;
    assign bus_as_     = as_q;
    assign bus_rw      = rw_q;
    assign bus_addr    = addr_q;
    assign bus_wr_data = wdata_q;

endmodule
